seal_verifier: RTL
==================

# seal_verifier

Receiving end of the seal-record path. Firmware writes back a 3-word sealed record, in the same word format the seal register emits on readout, plus the sensor_id. The block re-feeds the 9-byte message through the shared CRC16 engine, compares against the embedded CRC and checks ordering against the last accepted record. It sits beside the seal register on the peripheral bus and arbitrates for the same CRC engine instance.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- crc_byte  out  8  byte to CRC engine
- crc_feed  out  1  one-cycle feed strobe
- crc_init  out  1  one-cycle engine reset to 0xFFFF
- crc_busy  in  1  engine processing
- crc_value  in  16  engine result
- data_wr  in  1  VERIFY_DATA write strobe
- data_in  in  32  record word
- data_out  out  32  last_mono (last accepted mono_count)
- ctrl_wr  in  1  VERIFY_CTRL write strobe
- ctrl_in  in  10  {sensor_id[7:0], start, clear}
- ctrl_out  out  32  {pass_count[15:0], 8'b0, start_dropped, fmt_err, sid_err, mono_err, crc_err, pass, done, busy}

## Operation
- Record load, IDLE only: wr_seq (0..2) selects the target word.
  - Word 0 = value[31:0].
  - Word 1 = {sid[7:0], mono[23:0]}.
  - Word 2 = {mono[31:24], crc[15:0], fmt[7:0]}.
  - wr_seq wraps 2→0 and sets loaded=1.
  - A write to word 0 clears loaded.
  - data_wr outside IDLE is ignored.
- clear (ctrl_in[0]=1, IDLE):
  - Resets wr_seq, loaded, have_last, last_mono, last_sid, pass_count and all result bits.
  - If start and clear are both set, only clear is applied.
- start (ctrl_in[1]=1, clear=0, IDLE):
  - Latches sensor_id, clears result bits and start_dropped.
  - If loaded=0: fmt_err=1, done=1, no CRC activity, stays IDLE.
  - Otherwise goes to INIT and resets wr_seq to 0.
- start while busy: sets start_dropped (sticky) and is otherwise ignored.
- FSM:
  - IDLE: handles loads and commands as above.
  - INIT: pulse crc_init, byte_idx=0, go to FEED.
  - FEED: when !crc_busy, drive crc_byte=byte[byte_idx], pulse crc_feed, go to WAIT.
  - WAIT: ignore crc_busy on the first cycle. From the second cycle, when !crc_busy: if byte_idx==8 go to CHECK, else byte_idx+1 and go to FEED.
  - CHECK: one cycle, then IDLE.
- Byte order: sensor_id, value[7:0], value[15:8], value[23:16], value[31:24], mono[7:0] … mono[31:24].
- Checks in CHECK:
  - crc_err = crc_value != rec_crc.
  - mono_err = have_last && rec_mono <= last_mono (unsigned 32-bit).
  - sid_err = have_last && rec_sid != last_sid.
  - fmt_err = fmt != 8'h00.
  - pass = no error.
  - done=1 in all cases.
- On pass: last_mono ← rec_mono, last_sid ← rec_sid, have_last ← 1, pass_count +1, saturating at 0xFFFF.
- On fail: anchors and pass_count are unchanged. A replayed or backfilled record therefore always fails mono_err.

## Timing
- Reset values: all outputs and registers 0. FSM in IDLE, busy=0, done=0.
- busy is high from the cycle after the accepted start until CHECK completes.
- done/pass/error bits update at the CHECK→IDLE edge and hold until the next start or clear.
- Latency with a zero-wait engine and B busy cycles per byte: 1 (INIT) + 9×(2+B) + 1 (CHECK) cycles.
- crc_feed and crc_init are registered single-cycle pulses. They never assert together and never in consecutive cycles.
- Reset mid-verify: the FSM returns to IDLE immediately and no pulses are emitted in the following cycle.
- data_out and ctrl_out are combinational from registers; there is no read side effect.

## Structure
- Shared package seal_pkg holds:
  - Record word-field bit positions (shared with the seal register).
  - SEAL_MSG_BYTES=9.
  - Status bit indices.
  - FSM state localparams S_IDLE/S_INIT/S_FEED/S_WAIT/S_CHECK.
- One sub-module, seal_crc_feeder: the 9-byte mux plus the FEED/WAIT handshake with start/done. It is reusable by the seal register.

## Test plan
Expected CRC values come from a bench model of the shared engine.

- Valid record, fresh: sid 0x17, value 0xDEADBEEF, mono 0, correct CRC, sensor 0x42 → pass=1, pass_count=1, data_out=0.
- Same record replayed → mono_err=1, pass=0, pass_count stays 1. Record with mono 1 and sid 0x17 → pass, data_out=1.
- Flip crc bit 0 of word 2 → crc_err=1 only. Set word 2 fmt=0x01 → fmt_err=1. Use sid 0x18 with mono 5 → sid_err=1.
- start after only 2 writes → fmt_err=1, done=1, crc_feed never asserted. start during busy → start_dropped=1 and the current result is unaffected.
- crc_busy held high for 3 cycles per byte → exactly 9 feed pulses, latency 1+9×5+1=47 cycles, bytes in the specified order.
- rst_n low during byte 4 → status reads 0x00000000 and the next full verify passes. start+clear together → clear only, pass_count=0.

Source files
------------

// File: rtl/seal_pkg.sv
// Shared definitions for the seal-record path: record word layout, message size,
// status bit positions and FSM state encodings.
package seal_pkg;

   // Number of bytes fed through the CRC engine per record
   localparam int unsigned SEAL_MSG_BYTES = 9;
   localparam int unsigned SEAL_IDX_W     = 4;

   // Word 1 = {sid[7:0], mono[23:0]}
   localparam int unsigned W1_SID_MSB  = 31;
   localparam int unsigned W1_SID_LSB  = 24;
   localparam int unsigned W1_MONO_MSB = 23;
   localparam int unsigned W1_MONO_LSB = 0;

   // Word 2 = {mono[31:24], crc[15:0], fmt[7:0]}
   localparam int unsigned W2_MONO_MSB = 31;
   localparam int unsigned W2_MONO_LSB = 24;
   localparam int unsigned W2_CRC_MSB  = 23;
   localparam int unsigned W2_CRC_LSB  = 8;
   localparam int unsigned W2_FMT_MSB  = 7;
   localparam int unsigned W2_FMT_LSB  = 0;

   // Status word bit positions
   localparam int unsigned ST_BUSY          = 0;
   localparam int unsigned ST_DONE          = 1;
   localparam int unsigned ST_PASS          = 2;
   localparam int unsigned ST_CRC_ERR       = 3;
   localparam int unsigned ST_MONO_ERR      = 4;
   localparam int unsigned ST_SID_ERR       = 5;
   localparam int unsigned ST_FMT_ERR       = 6;
   localparam int unsigned ST_START_DROPPED = 7;
   localparam int unsigned ST_PCNT_LSB      = 16;
   localparam int unsigned ST_PCNT_MSB      = 31;

   typedef logic [2:0] seal_state_t;
   localparam seal_state_t S_IDLE  = 3'd0;
   localparam seal_state_t S_INIT  = 3'd1;
   localparam seal_state_t S_FEED  = 3'd2;
   localparam seal_state_t S_WAIT  = 3'd3;
   localparam seal_state_t S_CHECK = 3'd4;

   typedef logic [SEAL_MSG_BYTES-1:0][7:0] seal_msg_t;

   // Message byte order: sensor_id, value LSB..MSB, mono LSB..MSB
   function automatic seal_msg_t seal_build_msg(input logic [7:0]  sid,
                                                input logic [31:0] value,
                                                input logic [31:0] mono);
      seal_msg_t m;
      m[0] = sid;
      m[1] = value[7:0];
      m[2] = value[15:8];
      m[3] = value[23:16];
      m[4] = value[31:24];
      m[5] = mono[7:0];
      m[6] = mono[15:8];
      m[7] = mono[23:16];
      m[8] = mono[31:24];
      return m;
   endfunction

endpackage

// File: rtl/seal_crc_feeder.sv
// Walks the 9-byte seal message into the shared CRC engine, one byte per
// FEED/WAIT round trip, and flags done when the last byte has been absorbed.
module seal_crc_feeder
   import seal_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  seal_msg_t       msg,
   input  logic            crc_busy,
   output logic [7:0]      crc_byte,
   output logic            crc_feed,
   output logic            done
);

   localparam logic [SEAL_IDX_W-1:0] LastIdx = SEAL_IDX_W'(SEAL_MSG_BYTES - 1);

   seal_state_t           state_q, state_d;
   logic [SEAL_IDX_W-1:0] idx_q, idx_d;
   logic                  first_q, first_d;
   logic [7:0]            byte_q, byte_d;
   logic                  feed_q, feed_d;
   logic                  wait_ok;

   // The engine may not raise busy until after it sees the strobe, so the
   // first WAIT cycle never trusts crc_busy.
   assign wait_ok = (state_q == S_WAIT) && !first_q && !crc_busy;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: IDLE -> FEED -> WAIT -> (FEED | IDLE)
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FEED;
         S_FEED:  if (!crc_busy) state_d = S_WAIT;
         S_WAIT:  if (wait_ok) state_d = (idx_q == LastIdx) ? S_IDLE : S_FEED;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: done is a one-cycle flag on the last completed byte
   always_comb begin
      done = wait_ok && (idx_q == LastIdx);
   end

   // Byte index, registered byte/strobe and first-wait-cycle flag
   always_comb begin
      idx_d   = idx_q;
      byte_d  = byte_q;
      feed_d  = 1'b0;
      first_d = 1'b0;
      if (state_q == S_IDLE && start) idx_d = '0;
      if (state_q == S_FEED && !crc_busy) begin
         byte_d  = msg[idx_q];
         feed_d  = 1'b1;
         first_d = 1'b1;
      end
      if (wait_ok && idx_q != LastIdx) idx_d = idx_q + 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         byte_q  <= '0;
         feed_q  <= 1'b0;
         first_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         feed_q  <= feed_d;
         first_q <= first_d;
      end
   end

   assign crc_byte = byte_q;
   assign crc_feed = feed_q;

endmodule

// File: rtl/seal_verifier.sv
// Seal-record verifier: accepts a 3-word sealed record from firmware, re-runs
// the CRC through the shared engine and checks ordering against the last
// accepted record.
module seal_verifier
   import seal_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   output logic [7:0]  crc_byte,
   output logic        crc_feed,
   output logic        crc_init,
   input  logic        crc_busy,
   input  logic [15:0] crc_value,
   input  logic        data_wr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic        ctrl_wr,
   input  logic [9:0]  ctrl_in,
   output logic [31:0] ctrl_out
);

   seal_state_t state_q, state_d;

   logic [1:0]  wr_seq_q, wr_seq_d;
   logic        loaded_q, loaded_d;
   logic        have_last_q, have_last_d;
   logic [31:0] last_mono_q, last_mono_d;
   logic [7:0]  last_sid_q, last_sid_d;
   logic [15:0] pass_count_q, pass_count_d;
   logic [7:0]  sensor_id_q, sensor_id_d;
   logic [31:0] rec_value_q, rec_value_d;
   logic [7:0]  rec_sid_q, rec_sid_d;
   logic [31:0] rec_mono_q, rec_mono_d;
   logic [15:0] rec_crc_q, rec_crc_d;
   logic [7:0]  rec_fmt_q, rec_fmt_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        crc_err_q, crc_err_d;
   logic        mono_err_q, mono_err_d;
   logic        sid_err_q, sid_err_d;
   logic        fmt_err_q, fmt_err_d;
   logic        dropped_q, dropped_d;
   logic        crc_init_q, crc_init_d;

   logic        idle, busy, cmd_clear, cmd_start, start_go, feed_start, feed_done;
   logic        crc_err_c, mono_err_c, sid_err_c, fmt_err_c, pass_c;
   logic [31:0] status;
   seal_msg_t   msg;

   assign idle      = (state_q == S_IDLE);
   assign cmd_clear = ctrl_wr && ctrl_in[0];
   assign cmd_start = ctrl_wr && ctrl_in[1] && !ctrl_in[0];
   assign start_go  = idle && cmd_start && loaded_q;

   assign crc_err_c  = (crc_value != rec_crc_q);
   assign mono_err_c = have_last_q && (rec_mono_q <= last_mono_q);
   assign sid_err_c  = have_last_q && (rec_sid_q != last_sid_q);
   assign fmt_err_c  = (rec_fmt_q != 8'h00);
   assign pass_c     = !(crc_err_c || mono_err_c || sid_err_c || fmt_err_c);

   assign msg = seal_build_msg(sensor_id_q, rec_value_q, rec_mono_q);

   seal_crc_feeder u_feeder (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (feed_start),
      .msg      (msg),
      .crc_busy (crc_busy),
      .crc_byte (crc_byte),
      .crc_feed (crc_feed),
      .done     (feed_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state; S_FEED covers the whole feeder run (FEED/WAIT live in the feeder)
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_go) state_d = S_INIT;
         S_INIT:  state_d = S_FEED;
         S_FEED:  if (feed_done) state_d = S_CHECK;
         S_CHECK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; crc_init is registered so it is high during the INIT cycle
   always_comb begin
      busy       = !idle;
      crc_init_d = idle && (state_d == S_INIT);
      feed_start = (state_q == S_INIT);
   end

   // Record load, commands and result/anchor updates
   always_comb begin
      wr_seq_d     = wr_seq_q;
      loaded_d     = loaded_q;
      have_last_d  = have_last_q;
      last_mono_d  = last_mono_q;
      last_sid_d   = last_sid_q;
      pass_count_d = pass_count_q;
      sensor_id_d  = sensor_id_q;
      rec_value_d  = rec_value_q;
      rec_sid_d    = rec_sid_q;
      rec_mono_d   = rec_mono_q;
      rec_crc_d    = rec_crc_q;
      rec_fmt_d    = rec_fmt_q;
      done_d       = done_q;
      pass_d       = pass_q;
      crc_err_d    = crc_err_q;
      mono_err_d   = mono_err_q;
      sid_err_d    = sid_err_q;
      fmt_err_d    = fmt_err_q;
      dropped_d    = dropped_q;
      if (idle) begin
         if (cmd_clear) begin
            wr_seq_d     = 2'd0;
            loaded_d     = 1'b0;
            have_last_d  = 1'b0;
            last_mono_d  = '0;
            last_sid_d   = '0;
            pass_count_d = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            crc_err_d    = 1'b0;
            mono_err_d   = 1'b0;
            sid_err_d    = 1'b0;
            fmt_err_d    = 1'b0;
            dropped_d    = 1'b0;
         end else if (cmd_start) begin
            sensor_id_d = ctrl_in[9:2];
            done_d      = 1'b0;
            pass_d      = 1'b0;
            crc_err_d   = 1'b0;
            mono_err_d  = 1'b0;
            sid_err_d   = 1'b0;
            dropped_d   = 1'b0;
            // An incomplete record finishes immediately as a format error
            fmt_err_d   = !loaded_q;
            done_d      = !loaded_q;
            if (loaded_q) wr_seq_d = 2'd0;
         end else if (data_wr) begin
            case (wr_seq_q)
               2'd0: begin
                  rec_value_d = data_in;
                  loaded_d    = 1'b0;
                  wr_seq_d    = 2'd1;
               end
               2'd1: begin
                  rec_sid_d        = data_in[W1_SID_MSB:W1_SID_LSB];
                  rec_mono_d[23:0] = data_in[W1_MONO_MSB:W1_MONO_LSB];
                  wr_seq_d         = 2'd2;
               end
               2'd2: begin
                  rec_mono_d[31:24] = data_in[W2_MONO_MSB:W2_MONO_LSB];
                  rec_crc_d         = data_in[W2_CRC_MSB:W2_CRC_LSB];
                  rec_fmt_d         = data_in[W2_FMT_MSB:W2_FMT_LSB];
                  wr_seq_d          = 2'd0;
                  loaded_d          = 1'b1;
               end
               default: wr_seq_d = 2'd0;
            endcase
         end
      end else begin
         if (cmd_start) dropped_d = 1'b1;
         if (state_q == S_CHECK) begin
            done_d     = 1'b1;
            pass_d     = pass_c;
            crc_err_d  = crc_err_c;
            mono_err_d = mono_err_c;
            sid_err_d  = sid_err_c;
            fmt_err_d  = fmt_err_c;
            if (pass_c) begin
               last_mono_d = rec_mono_q;
               last_sid_d  = rec_sid_q;
               have_last_d = 1'b1;
               if (pass_count_q != 16'hFFFF) pass_count_d = pass_count_q + 16'd1;
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_seq_q     <= '0;
         loaded_q     <= 1'b0;
         have_last_q  <= 1'b0;
         last_mono_q  <= '0;
         last_sid_q   <= '0;
         pass_count_q <= '0;
         sensor_id_q  <= '0;
         rec_value_q  <= '0;
         rec_sid_q    <= '0;
         rec_mono_q   <= '0;
         rec_crc_q    <= '0;
         rec_fmt_q    <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         crc_err_q    <= 1'b0;
         mono_err_q   <= 1'b0;
         sid_err_q    <= 1'b0;
         fmt_err_q    <= 1'b0;
         dropped_q    <= 1'b0;
         crc_init_q   <= 1'b0;
      end else begin
         wr_seq_q     <= wr_seq_d;
         loaded_q     <= loaded_d;
         have_last_q  <= have_last_d;
         last_mono_q  <= last_mono_d;
         last_sid_q   <= last_sid_d;
         pass_count_q <= pass_count_d;
         sensor_id_q  <= sensor_id_d;
         rec_value_q  <= rec_value_d;
         rec_sid_q    <= rec_sid_d;
         rec_mono_q   <= rec_mono_d;
         rec_crc_q    <= rec_crc_d;
         rec_fmt_q    <= rec_fmt_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         crc_err_q    <= crc_err_d;
         mono_err_q   <= mono_err_d;
         sid_err_q    <= sid_err_d;
         fmt_err_q    <= fmt_err_d;
         dropped_q    <= dropped_d;
         crc_init_q   <= crc_init_d;
      end
   end

   // Status word assembly
   always_comb begin
      status                          = '0;
      status[ST_BUSY]                 = busy;
      status[ST_DONE]                 = done_q;
      status[ST_PASS]                 = pass_q;
      status[ST_CRC_ERR]              = crc_err_q;
      status[ST_MONO_ERR]             = mono_err_q;
      status[ST_SID_ERR]              = sid_err_q;
      status[ST_FMT_ERR]              = fmt_err_q;
      status[ST_START_DROPPED]        = dropped_q;
      status[ST_PCNT_MSB:ST_PCNT_LSB] = pass_count_q;
   end

   assign ctrl_out = status;
   assign data_out = last_mono_q;
   assign crc_init = crc_init_q;

endmodule
